// File: rtl/rv32i_types.sv
// Shared RV32I core types: opcodes, decoded instruction, result broadcast,
// load/store queue entry and reorder buffer entry.
package rv32i_types;

  localparam int TAG_W = 4;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } pci_t;

  // Tag/ready/data triple used both for CDB broadcasts and ROB snooping.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [31:0]      data;
  } sal_t;

  typedef struct packed {
    logic             valid;
    logic             is_store;
    logic [TAG_W-1:0] rob_tag;
    sal_t             addr;
    sal_t             wdata;
  } lsq_t;

  typedef struct packed {
    logic        valid;
    logic        rdy;
    rv32i_opcode opcode;
    logic [4:0]  rd;
    logic [31:0] data;
  } rob_entry_t;

  function automatic logic writes_rd(rv32i_opcode op, logic [4:0] rd);
    return (rd != 5'd0) && (op != op_store) && (op != op_br);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, captures CDB results,
// exposes per-entry state on rob_bus and retires in program order.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int size    = 8,
  parameter int num_cdb = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  input  pci_t             instruction,
  output logic [TAG_W-1:0] rob_tag,
  output logic             rob_stall,
  input  sal_t             cdb [num_cdb],
  output sal_t             rob_bus [size],
  output logic             commit_valid,
  output logic             commit_we,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_data,
  output logic [TAG_W-1:0] commit_tag
);

  localparam int PTR_W = $clog2(size);
  localparam int CNT_W = $clog2(size + 1);

  rob_entry_t       entry_q [size];
  rob_entry_t       entry_d [size];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full;
  logic             issue_fire;
  rob_entry_t       head_e;
  logic             cap_hit  [size];
  logic [31:0]      cap_data [size];
  logic             unused_inst;

  assign unused_inst = ^{instruction.rs1, instruction.rs2, instruction.funct3, instruction.imm};

  assign full       = (count_q == CNT_W'(size));
  assign issue_fire = issue_valid && !full && !flush;
  assign rob_stall  = full;
  assign rob_tag    = TAG_W'(tail_q);

  assign head_e       = entry_q[head_q];
  assign commit_valid = head_e.valid && head_e.rdy && !flush;
  assign commit_we    = commit_valid && writes_rd(head_e.opcode, head_e.rd);
  assign commit_rd    = head_e.rd;
  assign commit_data  = head_e.data;
  assign commit_tag   = TAG_W'(head_q);

  // Per-entry priority match across broadcasts; the lowest cdb index wins.
  always_comb begin
    for (int i = 0; i < size; i++) begin
      cap_hit[i]  = 1'b0;
      cap_data[i] = 32'd0;
      for (int k = 0; k < num_cdb; k++) begin
        if (!cap_hit[i] && cdb[k].rdy && (cdb[k].tag == TAG_W'(i))) begin
          cap_hit[i]  = 1'b1;
          cap_data[i] = cdb[k].data;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < size; i++) begin
      entry_d[i] = entry_q[i];
      if (cap_hit[i] && entry_q[i].valid && !entry_q[i].rdy) begin
        entry_d[i].rdy  = 1'b1;
        entry_d[i].data = cap_data[i];
      end
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(issue_fire) - CNT_W'(commit_valid);

    if (commit_valid) begin
      entry_d[head_q].valid = 1'b0;
      head_d = (head_q == PTR_W'(size - 1)) ? '0 : head_q + 1'b1;
    end

    if (issue_fire) begin
      entry_d[tail_q] = '{valid: 1'b1, rdy: 1'b0, opcode: instruction.opcode,
                          rd: instruction.rd, data: 32'd0};
      tail_d = (tail_q == PTR_W'(size - 1)) ? '0 : tail_q + 1'b1;
    end

    // Mispredict recovery wipes everything, whatever else happened this cycle.
    if (flush) begin
      for (int i = 0; i < size; i++) begin
        entry_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < size; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < size; i++) begin
        entry_q[i] <= entry_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < size; i++) begin
      rob_bus[i].tag  = TAG_W'(i);
      rob_bus[i].rdy  = entry_q[i].valid && entry_q[i].rdy;
      rob_bus[i].data = entry_q[i].valid ? entry_q[i].data : 32'd0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
  import rv32i_types::*;

  localparam int SIZE = 8;
  localparam int NCDB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             issue_valid;
  pci_t             instruction;
  logic [TAG_W-1:0] rob_tag;
  logic             rob_stall;
  sal_t             cdb [NCDB];
  sal_t             rob_bus [SIZE];
  logic             commit_valid;
  logic             commit_we;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_data;
  logic [TAG_W-1:0] commit_tag;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.size(SIZE), .num_cdb(NCDB)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .instruction  (instruction),
    .rob_tag      (rob_tag),
    .rob_stall    (rob_stall),
    .cdb          (cdb),
    .rob_bus      (rob_bus),
    .commit_valid (commit_valid),
    .commit_we    (commit_we),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .commit_tag   (commit_tag)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0;
    flush       = 1'b0;
    instruction = '0;
    for (int k = 0; k < NCDB; k++) cdb[k] = '0;
  endtask

  task automatic apply_stimulus(input rv32i_opcode op, input logic [4:0] rd);
    instruction        = '0;
    instruction.opcode = op;
    instruction.rd     = rd;
    issue_valid        = 1'b1;
  endtask

  task automatic broadcast(input int k, input int tag, input logic [31:0] data);
    cdb[k].tag  = TAG_W'(tag);
    cdb[k].rdy  = 1'b1;
    cdb[k].data = data;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset then idle
    apply_reset();
    check_output("reset_stall", rob_stall, 0);
    check_output("reset_tag", rob_tag, 0);
    check_output("reset_cv", commit_valid, 0);
    check_output("reset_we", commit_we, 0);
    check_output("reset_rd", commit_rd, 0);
    check_output("reset_data", commit_data, 0);
    check_output("reset_ctag", commit_tag, 0);
    for (int i = 0; i < SIZE; i++) begin
      check_output($sformatf("reset_bus_rdy%0d", i), rob_bus[i].rdy, 0);
      check_output($sformatf("reset_bus_tag%0d", i), rob_bus[i].tag, i);
      check_output($sformatf("reset_bus_data%0d", i), rob_bus[i].data, 0);
    end

    // Single instruction: addi x5 -> tag 0, result 0x2A
    apply_stimulus(op_imm, 5'd5);
    step();
    clear_inputs();
    check_output("single_tag_next", rob_tag, 1);
    check_output("single_not_rdy", rob_bus[0].rdy, 0);
    check_output("single_cv_wait", commit_valid, 0);
    broadcast(1, 0, 32'h2A);
    step();
    clear_inputs();
    check_output("single_bus_rdy", rob_bus[0].rdy, 1);
    check_output("single_bus_data", rob_bus[0].data, 32'h2A);
    check_output("single_cv", commit_valid, 1);
    check_output("single_we", commit_we, 1);
    check_output("single_rd", commit_rd, 5);
    check_output("single_data", commit_data, 32'h2A);
    check_output("single_ctag", commit_tag, 0);
    step();
    check_output("single_after_cv", commit_valid, 0);
    check_output("single_after_bus", rob_bus[0].rdy, 0);

    // Out-of-order results, in-order commits
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(op_reg, 5'(i + 1));
      step();
    end
    clear_inputs();
    check_output("ooo_tag", rob_tag, 3);
    broadcast(0, 2, 32'h300);
    step();
    clear_inputs();
    check_output("ooo_t2_cv", commit_valid, 0);
    check_output("ooo_t2_bus", rob_bus[2].rdy, 1);
    broadcast(3, 1, 32'h200);
    step();
    clear_inputs();
    check_output("ooo_t1_cv", commit_valid, 0);
    broadcast(2, 0, 32'h100);
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("ooo_cv%0d", i), commit_valid, 1);
      check_output($sformatf("ooo_ctag%0d", i), commit_tag, i);
      check_output($sformatf("ooo_cdata%0d", i), commit_data, 32'h100 * (i + 1));
      check_output($sformatf("ooo_crd%0d", i), commit_rd, i + 1);
      step();
    end
    check_output("ooo_done_cv", commit_valid, 0);

    // Fill, refuse, and wrap
    apply_reset();
    for (int i = 0; i < SIZE; i++) begin
      check_output($sformatf("fill_stall%0d", i), rob_stall, 0);
      apply_stimulus(op_imm, 5'(i + 1));
      step();
    end
    clear_inputs();
    check_output("fill_full", rob_stall, 1);
    check_output("fill_tag_wrap", rob_tag, 0);
    apply_stimulus(op_imm, 5'd20);
    step();
    clear_inputs();
    check_output("fill_refused_tag", rob_tag, 0);
    check_output("fill_refused_stall", rob_stall, 1);
    broadcast(0, 0, 32'hAA);
    step();
    clear_inputs();
    check_output("fill_head_cv", commit_valid, 1);
    check_output("fill_head_stall", rob_stall, 1);
    apply_stimulus(op_imm, 5'd21);
    step();
    check_output("fill_c_refused_tag", rob_tag, 0);
    check_output("fill_c_stall", rob_stall, 0);
    step();
    clear_inputs();
    check_output("fill_reuse_tag", rob_tag, 1);
    check_output("fill_reuse_stall", rob_stall, 1);
    check_output("fill_reuse_rdy", rob_bus[0].rdy, 0);
    check_output("fill_next_head", commit_tag, 1);

    // Special commits and duplicate-tag priority
    apply_reset();
    apply_stimulus(op_store, 5'd3);
    step();
    apply_stimulus(op_imm, 5'd0);
    step();
    apply_stimulus(op_br, 5'd4);
    step();
    apply_stimulus(op_reg, 5'd7);
    step();
    clear_inputs();
    broadcast(0, 3, 32'h111);
    broadcast(1, 0, 32'h5);
    broadcast(2, 3, 32'h999);
    broadcast(3, 1, 32'h6);
    step();
    clear_inputs();
    check_output("dup_data", rob_bus[3].data, 32'h111);
    check_output("store_cv", commit_valid, 1);
    check_output("store_we", commit_we, 0);
    step();
    check_output("x0_cv", commit_valid, 1);
    check_output("x0_we", commit_we, 0);
    check_output("x0_data", commit_data, 32'h6);
    step();
    check_output("br_wait_cv", commit_valid, 0);
    broadcast(0, 2, 32'h7);
    step();
    clear_inputs();
    check_output("br_cv", commit_valid, 1);
    check_output("br_we", commit_we, 0);
    step();
    check_output("reg_cv", commit_valid, 1);
    check_output("reg_we", commit_we, 1);
    check_output("reg_rd", commit_rd, 7);
    check_output("reg_data", commit_data, 32'h111);
    step();
    check_output("special_empty_cv", commit_valid, 0);
    check_output("special_tag", rob_tag, 4);
    apply_stimulus(op_imm, 5'd9);
    broadcast(0, 4, 32'hDEAD);
    broadcast(1, 6, 32'hBEEF);
    step();
    clear_inputs();
    check_output("alloc_bcast_rdy", rob_bus[4].rdy, 0);
    check_output("alloc_bcast_data", rob_bus[4].data, 0);
    check_output("invalid_bcast_rdy", rob_bus[6].rdy, 0);
    check_output("alloc_cv", commit_valid, 0);

    // Flush mid-operation
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(op_imm, 5'(i + 1));
      step();
    end
    clear_inputs();
    broadcast(0, 0, 32'h10);
    broadcast(1, 2, 32'h12);
    step();
    clear_inputs();
    check_output("flush_pre_cv", commit_valid, 1);
    flush = 1'b1;
    apply_stimulus(op_imm, 5'd8);
    broadcast(0, 3, 32'h13);
    #1;
    check_output("flush_cycle_cv", commit_valid, 0);
    check_output("flush_cycle_we", commit_we, 0);
    step();
    clear_inputs();
    check_output("flush_tag", rob_tag, 0);
    check_output("flush_stall", rob_stall, 0);
    check_output("flush_cv", commit_valid, 0);
    for (int i = 0; i < SIZE; i++) begin
      check_output($sformatf("flush_bus_rdy%0d", i), rob_bus[i].rdy, 0);
    end
    for (int i = 0; i < SIZE; i++) begin
      apply_stimulus(op_imm, 5'(i + 1));
      step();
      check_output($sformatf("flush_count%0d", i), rob_stall, (i == SIZE - 1) ? 1 : 0);
    end
    clear_inputs();

    // Reset mid-operation discards the resolving head
    broadcast(0, 0, 32'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    check_output("rst_mid_rdy", rob_bus[0].rdy, 0);
    check_output("rst_mid_cv", commit_valid, 0);
    check_output("rst_mid_stall", rob_stall, 0);
    check_output("rst_mid_tag", rob_tag, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
